// File: rtl/scoreboard_pkg.sv
// Shared types for the scoreboard and its functional units.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpAnd = 2'd2,
    OpMul = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StExec  = 2'd2,
    StWrite = 2'd3
  } fu_state_e;

endpackage

// File: rtl/scoreboard_fu_alu.sv
// Combinational datapath of the functional unit; every result wraps modulo 2^w_data.
module scoreboard_fu_alu
  import scoreboard_pkg::*;
#(
  parameter int unsigned w_data = 8
) (
  input  op_e               i_op,
  input  logic [w_data-1:0] i_a,
  input  logic [w_data-1:0] i_b,
  output logic [w_data-1:0] o_result
);

  always_comb begin
    o_result = '0;
    unique case (i_op)
      OpAdd: o_result = i_a + i_b;
      OpSub: o_result = i_a - i_b;
      OpAnd: o_result = i_a & i_b;
      OpMul: o_result = i_a * i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/scoreboard_fu.sv
// Scoreboard functional unit: issue, operand read, fixed-latency execute, write-back handshake.
module scoreboard_fu
  import scoreboard_pkg::*;
#(
  parameter int unsigned w_data  = 8,
  parameter int unsigned w_reg   = 3,
  parameter int unsigned lat_alu = 2,
  parameter int unsigned lat_mul = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_op,
  input  logic [w_reg-1:0]  issue_dst,
  input  logic [w_reg-1:0]  issue_src1,
  input  logic [w_reg-1:0]  issue_src2,
  output logic              rd_req,
  output logic [w_reg-1:0]  rd_src1,
  output logic [w_reg-1:0]  rd_src2,
  input  logic              rd_grant,
  input  logic [w_data-1:0] rd_data1,
  input  logic [w_data-1:0] rd_data2,
  output logic              wr_req,
  output logic [w_reg-1:0]  wr_dst,
  output logic [w_data-1:0] wr_data,
  input  logic              wr_grant,
  input  logic              kill,
  output logic              busy
);

  localparam int unsigned LatMax = (lat_alu > lat_mul) ? lat_alu : lat_mul;
  localparam int unsigned CntW   = $clog2(LatMax + 1);
  localparam logic [CntW-1:0] LatAluM1 = CntW'(lat_alu - 1);
  localparam logic [CntW-1:0] LatMulM1 = CntW'(lat_mul - 1);

  fu_state_e          r_state;
  logic [CntW-1:0]    r_cnt;
  op_e                r_op;
  logic [w_reg-1:0]   r_dst, r_src1, r_src2;
  logic [w_data-1:0]  r_a, r_b, r_wr_data;

  logic [CntW-1:0]    w_lat_m1;
  logic [w_data-1:0]  w_alu_a, w_alu_b, w_alu_res;

  // A one-cycle latency skips EXEC, so the ALU must then see the operands being granted.
  assign w_alu_a  = (r_state == StRead) ? rd_data1 : r_a;
  assign w_alu_b  = (r_state == StRead) ? rd_data2 : r_b;
  assign w_lat_m1 = (r_op == OpMul) ? LatMulM1 : LatAluM1;

  scoreboard_fu_alu #(
    .w_data(w_data)
  ) u_alu (
    .i_op    (r_op),
    .i_a     (w_alu_a),
    .i_b     (w_alu_b),
    .o_result(w_alu_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_op      <= OpAdd;
      r_dst     <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_wr_data <= '0;
    end else if (kill) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (issue_valid) begin
            r_op    <= op_e'(issue_op);
            r_dst   <= issue_dst;
            r_src1  <= issue_src1;
            r_src2  <= issue_src2;
            r_state <= StRead;
          end
        end
        StRead: begin
          if (rd_grant) begin
            r_a <= rd_data1;
            r_b <= rd_data2;
            if (w_lat_m1 == '0) begin
              r_wr_data <= w_alu_res;
              r_state   <= StWrite;
            end else begin
              r_cnt   <= w_lat_m1;
              r_state <= StExec;
            end
          end
        end
        StExec: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= CntW'(1)) begin
            r_wr_data <= w_alu_res;
            r_state   <= StWrite;
          end
        end
        StWrite: begin
          if (wr_grant) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign issue_ready = (r_state == StIdle);
  assign busy        = (r_state != StIdle);
  assign rd_req      = (r_state == StRead);
  assign wr_req      = (r_state == StWrite);
  assign rd_src1     = r_src1;
  assign rd_src2     = r_src2;
  assign wr_dst      = r_dst;
  assign wr_data     = r_wr_data;

endmodule

// File: doc/scoreboard_fu.md
SCOREBOARD_FU -- requirements
Module: scoreboard_fu

Interface
REQ-001 Parameter w_data, default 8, width of operand and result data.
REQ-002 Parameter w_reg, default 3, width of register-number fields (8 registers).
REQ-003 Parameter lat_alu, default 2, cycles from read grant to write request for ADD/SUB/AND (minimum 1).
REQ-004 Parameter lat_mul, default 5, cycles from read grant to write request for MUL (minimum 1).
REQ-005 clk  input  1  the only clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 issue_valid  input  1  scoreboard offers an instruction.
REQ-008 issue_ready  output  1  unit idle; offer accepted this cycle when issue_valid is also high.
REQ-009 issue_op  input  2  opcode: 0 ADD, 1 SUB, 2 AND, 3 MUL.
REQ-010 issue_dst / issue_src1 / issue_src2  input  w_reg each  destination and source register numbers.
REQ-011 rd_req  output  1  request to read operands.
REQ-012 rd_src1 / rd_src2  output  w_reg each  registers to read.
REQ-013 rd_grant  input  1  scoreboard grants the read; rd_data1/rd_data2 are valid in the same cycle.
REQ-014 rd_data1 / rd_data2  input  w_data each  operand values.
REQ-015 wr_req  output  1  result ready; request to write it.
REQ-016 wr_dst  output  w_reg  destination register.
REQ-017 wr_data  output  w_data  result value.
REQ-018 wr_grant  input  1  scoreboard accepts the write (no WAR hazard).
REQ-019 kill  input  1  synchronous abort of the current instruction.
REQ-020 busy  output  1  unit holds an instruction (state not IDLE).

Function
REQ-021 The FSM SHALL have four states: IDLE, READ, EXEC and WRITE.
REQ-022 issue_ready SHALL be combinationally equal to (state == IDLE) and SHALL NOT depend on issue_valid.
REQ-023 On issue_valid && issue_ready, op, dst, src1 and src2 SHALL be latched and the FSM SHALL enter READ.
REQ-024 In READ, rd_req SHALL be 1 and rd_src1/rd_src2 SHALL show the latched sources.
REQ-025 On rd_grant in READ, rd_data1/rd_data2 SHALL be latched, the latency counter SHALL be loaded, and the FSM SHALL enter EXEC.
REQ-026 wr_req SHALL rise exactly lat_alu (ADD/SUB/AND) or lat_mul (MUL) cycles after the grant cycle.
REQ-027 In EXEC, the counter SHALL decrement every cycle, and the FSM SHALL enter WRITE when it expires.
REQ-028 The counter width SHALL be $clog2(max(lat_alu, lat_mul) + 1).
REQ-029 Results SHALL be taken modulo 2^w_data: SUB = a - b with wrap, MUL = low w_data bits of a*b, and no overflow flag is produced.
REQ-030 In WRITE, wr_req, wr_dst and wr_data SHALL stay stable until the wr_grant cycle.
REQ-031 On wr_grant, the FSM SHALL return to IDLE, and issue_ready SHALL be 1 in the following cycle (no same-cycle re-issue).
REQ-032 rd_grant outside READ and wr_grant outside WRITE SHALL be ignored.
REQ-033 issue_valid while busy SHALL be ignored, with no latching.
REQ-034 kill SHALL return the FSM to IDLE on the next edge from any state and discard the instruction; kill has priority over simultaneous grants and issue.
REQ-035 rd_req and wr_req SHALL be 0 in IDLE and EXEC.

Reset
REQ-036 While rst is high, state SHALL be IDLE and the counter 0.
REQ-037 While rst is high, outputs SHALL be: rd_req=0, wr_req=0, busy=0, issue_ready=1, and wr_data, wr_dst, rd_src1, rd_src2 all 0.
REQ-038 Reset asserted mid-operation SHALL abandon the instruction with no write request.

Structure
REQ-039 Shared package scoreboard_pkg SHALL hold the opcode enum (ADD, SUB, AND, MUL) and the FSM state enum, for reuse by the scoreboard.
REQ-040 One combinational sub-module, scoreboard_fu_alu (op, a, b -> result), SHALL compute the result; all sequencing stays in scoreboard_fu.

Verification
REQ-041 ADD: issue ADD dst=3 src=1,2, grant with 8'd200 and 8'd100 -> wr_req 2 cycles after grant, wr_dst=3, wr_data=8'd44.
REQ-042 MUL: issue MUL, grant with 8'd15 and 8'd17 -> wr_req exactly 5 cycles after grant, wr_data=8'd255.
REQ-043 Write stall: hold wr_grant=0 for 10 cycles -> wr_req, wr_dst and wr_data stable, busy=1, issue_ready=0 throughout; grant -> IDLE next cycle.
REQ-044 Busy issue: pulse issue_valid with SUB during EXEC of an AND -> ignored; only the AND result is written; then issue SUB 8'd3 - 8'd5 -> 8'd254.
REQ-045 kill in READ with simultaneous rd_grant -> next cycle IDLE, no wr_req ever; rst asserted during EXEC -> outputs at reset values immediately.
